// File: rtl/mem_stream_reader_if.sv
// Memory read bus plus the character stream toward the LCD writer.
// The reader drives the master side; memory and LCD writer sit on the slave side.
interface mem_stream_reader_if #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 8
);
    logic [ADDR_W-1:0] mem_addr;
    logic [1:0]        mem_rw;
    logic [DATA_W-1:0] mem_save;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output mem_addr, mem_rw, out_data, out_valid,
        input  mem_save, out_ready
    );

    modport slave (
        input  mem_addr, mem_rw, out_data, out_valid,
        output mem_save, out_ready
    );
endinterface

// File: rtl/mem_stream_reader.sv
// Read-side sequencer for the 16x8 character memory: reads one frame of bytes
// and hands each to the LCD character writer over valid/ready, one at a time.
module mem_stream_reader #(
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIRST_ADDR = 0,
    parameter int unsigned LAST_ADDR  = 15,
    parameter int unsigned NUL_STOP   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    loop_en,
    input  logic                    abort,
    mem_stream_reader_if.master     bus,
    output logic                    busy,
    output logic                    done
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_CAPTURE = 3'd2,
        S_PRESENT = 3'd3,
        S_FINISH  = 3'd4
    } state_t;

    localparam logic [1:0] RW_READ = 2'b11;
    localparam logic [1:0] RW_NONE = 2'b00;
    localparam logic [ADDR_W-1:0] A_FIRST = ADDR_W'(FIRST_ADDR);
    localparam logic [ADDR_W-1:0] A_LAST  = ADDR_W'(LAST_ADDR);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        rw_q, rw_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;
    logic              busy_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            rw_q    <= RW_NONE;
            data_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rw_q    <= rw_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            busy_q  <= (state_d != S_IDLE);
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rw_d    = rw_q;
        data_d  = data_q;
        valid_d = valid_q;
        done_d  = 1'b0;

        // abort overrides every other event in every state
        if (abort) begin
            valid_d = 1'b0;
            rw_d    = RW_NONE;
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        addr_d  = A_FIRST;
                        rw_d    = RW_READ;
                        state_d = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    rw_d    = RW_READ;
                    state_d = S_CAPTURE;
                end
                S_CAPTURE: begin
                    data_d = bus.mem_save;
                    rw_d   = RW_NONE;
                    if ((NUL_STOP != 0) && (bus.mem_save == '0)) begin
                        state_d = S_FINISH;
                    end else begin
                        valid_d = 1'b1;
                        state_d = S_PRESENT;
                    end
                end
                S_PRESENT: begin
                    if (bus.out_ready) begin
                        valid_d = 1'b0;
                        if (addr_q == A_LAST) begin
                            state_d = S_FINISH;
                        end else begin
                            addr_d  = addr_q + 1'b1;
                            rw_d    = RW_READ;
                            state_d = S_ISSUE;
                        end
                    end
                end
                S_FINISH: begin
                    done_d = 1'b1;
                    if (loop_en) begin
                        addr_d  = A_FIRST;
                        rw_d    = RW_READ;
                        state_d = S_ISSUE;
                    end else begin
                        rw_d    = RW_NONE;
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    rw_d    = RW_NONE;
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_addr  = addr_q;
    assign bus.mem_rw    = rw_q;
    assign bus.out_data  = data_q;
    assign bus.out_valid = valid_q;
    assign busy          = busy_q;
    assign done          = done_q;
endmodule

// File: tb/tb_mem_stream_reader.sv
// Directed bench for mem_stream_reader with a registered-read memory model
// and a stream monitor collecting every accepted byte.
module tb_mem_stream_reader;
    logic clk;
    logic rst;
    logic start;
    logic loop_en;
    logic abort;
    logic busy;
    logic done;

    mem_stream_reader_if #(.ADDR_W(5), .DATA_W(8)) bus ();

    mem_stream_reader #(
        .ADDR_W(5), .DATA_W(8), .FIRST_ADDR(0), .LAST_ADDR(15), .NUL_STOP(1)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .loop_en(loop_en), .abort(abort),
        .bus(bus), .busy(busy), .done(done)
    );

    logic [7:0] mem [0:31];
    logic [7:0] acc_q [$];
    int         acc_cyc [$];
    int         cyc;
    int         done_cnt;
    int         total;
    int         bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // registered read: data appears one clock after an edge with rw=11
    always @(posedge clk) begin
        cyc <= cyc + 1;
        bus.mem_save <= (bus.mem_rw == 2'b11) ? mem[bus.mem_addr] : 8'h00;
    end

    always @(negedge clk) begin
        if (bus.out_valid && bus.out_ready && !abort) begin
            acc_q.push_back(bus.out_data);
            acc_cyc.push_back(cyc);
        end
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_str(input logic [127:0] s);
        for (int i = 0; i < 32; i++) mem[i] = (i < 16) ? s[127-8*i -: 8] : 8'h00;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int target, input string tag);
        for (int i = 0; i < 400 && done_cnt < target; i++) tick();
        check(tag, done_cnt, target);
    endtask

    task automatic check_frame(input string tag, input int n);
        check({tag, "_count"}, acc_q.size(), n);
        for (int i = 0; i < n && i < acc_q.size(); i++)
            check($sformatf("%s_b%0d", tag, i), acc_q[i], mem[i % 16]);
    endtask

    task automatic clear_stats();
        acc_q.delete();
        acc_cyc.delete();
        done_cnt = 0;
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0; done_cnt = 0;
        rst = 1'b0; start = 1'b0; loop_en = 1'b0; abort = 1'b0;
        bus.out_ready = 1'b1;
        load_str("HELLO WORLD!ABCD");
        tick(); tick();
        check("rst_addr", bus.mem_addr, 0);
        check("rst_rw", bus.mem_rw, 0);
        check("rst_data", bus.out_data, 0);
        check("rst_valid", bus.out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b1;
        tick();

        // full 16-byte frame, ready held high
        clear_stats();
        pulse_start();
        check("t1_issue_rw", bus.mem_rw, 2'b11);
        check("t1_issue_addr", bus.mem_addr, 0);
        check("t1_issue_busy", busy, 1);
        check("t1_issue_valid", bus.out_valid, 0);
        tick();
        check("t1_capture_valid", bus.out_valid, 0);
        tick();
        check("t1_first_valid", bus.out_valid, 1);
        check("t1_first_data", bus.out_data, 8'h48);
        wait_done(1, "t1_done_seen");
        check("t1_busy_at_done", busy, 0);
        check_frame("t1", 16);
        for (int i = 1; i < acc_cyc.size(); i++)
            check($sformatf("t1_gap%0d", i), acc_cyc[i] - acc_cyc[i-1], 3);
        tick(); tick();
        check("t1_done_once", done_cnt, 1);

        // NUL-terminated frame
        clear_stats();
        load_str({"HI", 8'h00, "ZZZZZZZZZZZZZ"});
        pulse_start();
        wait_done(1, "t2_done_seen");
        check_frame("t2", 2);
        check("t2_addr_stop", bus.mem_addr, 2);
        check("t2_busy", busy, 0);

        // back-pressure on the third byte
        clear_stats();
        load_str("HELLO WORLD!ABCD");
        pulse_start();
        for (int i = 0; i < 100 && !(bus.out_valid && bus.mem_addr == 2); i++) tick();
        check("t3_reach_byte3", bus.out_valid && bus.mem_addr == 2, 1);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("t3_hold_valid%0d", i), bus.out_valid, 1);
            check($sformatf("t3_hold_data%0d", i), bus.out_data, 8'h4C);
            check($sformatf("t3_hold_rw%0d", i), bus.mem_rw, 0);
            check($sformatf("t3_hold_addr%0d", i), bus.mem_addr, 2);
        end
        bus.out_ready = 1'b1;
        wait_done(1, "t3_done_seen");
        check_frame("t3", 16);

        // looping: two identical frames, one done per frame
        clear_stats();
        loop_en = 1'b1;
        pulse_start();
        for (int i = 0; i < 200 && !done; i++) tick();
        check("t4_done1", done, 1);
        check("t4_wrap_addr", bus.mem_addr, 0);
        check("t4_wrap_rw", bus.mem_rw, 2'b11);
        check("t4_wrap_busy", busy, 1);
        for (int i = 0; i < 200 && acc_q.size() < 32; i++) tick();
        loop_en = 1'b0;
        wait_done(2, "t4_done_count");
        check_frame("t4", 32);
        check("t4_busy_end", busy, 0);

        // abort while presenting address 7
        clear_stats();
        pulse_start();
        for (int i = 0; i < 100 && !(bus.out_valid && bus.mem_addr == 7); i++) tick();
        check("t5_reach_addr7", bus.out_valid && bus.mem_addr == 7, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t5_valid", bus.out_valid, 0);
        check("t5_busy", busy, 0);
        check("t5_rw", bus.mem_rw, 0);
        for (int i = 0; i < 10; i++) tick();
        check("t5_no_done", done_cnt, 0);
        check("t5_bytes", acc_q.size(), 7);

        // asynchronous reset during CAPTURE, then a clean frame
        clear_stats();
        pulse_start();
        tick();
        #2 rst = 1'b0;
        #1;
        check("t6_addr", bus.mem_addr, 0);
        check("t6_rw", bus.mem_rw, 0);
        check("t6_data", bus.out_data, 0);
        check("t6_valid", bus.out_valid, 0);
        check("t6_busy", busy, 0);
        check("t6_done", done, 0);
        tick();
        rst = 1'b1;
        tick(); tick();
        check("t6_idle_valid", bus.out_valid, 0);
        check("t6_no_partial", acc_q.size(), 0);
        pulse_start();
        wait_done(1, "t6_done_seen");
        check_frame("t6", 16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
